alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ERR_CNT_W, 4, width of overflow-event counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1 each  requester has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  operation accepted this cycle.
REQ-006 req0_op / req1_op  input  2 each  ALU opcode: 00 add, 01 sub, 10 NAND, 11 XOR.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  4 each  operands.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_id  output  1  requester index owning result.
REQ-011 rsp_data  output  4  ALU result.
REQ-012 rsp_err  output  1  signed overflow, add/sub only.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 err_cnt  output  ERR_CNT_W  overflow-event count (see Configuration).

Function
REQ-015 FSM SHALL have states IDLE, EXEC, RESP.
REQ-016 IDLE: if any valid, SHALL grant one requester, assert its ready combinationally that cycle, latch op/a/b/id, go EXEC; else stay IDLE.
REQ-017 Ready SHALL be asserted only in IDLE, to at most one requester.
REQ-018 Both valid: SHALL grant requester named by round-robin pointer; single valid: grant it regardless of pointer.
REQ-019 Pointer SHALL flip to the non-granted index on every grant.
REQ-020 EXEC: SHALL drive shared ALU from latched operands, register result into rsp_data/rsp_err/rsp_id, go RESP (one cycle).
REQ-021 RESP: rsp_valid SHALL be 1; rsp_data/rsp_err/rsp_id SHALL hold stable until rsp_valid&&rsp_ready, then go IDLE.
REQ-022 Latency: accept at cycle N, rsp_valid at N+2; best-case throughput one op per 3 cycles.
REQ-023 rsp_err SHALL equal two's-complement 4-bit overflow for op 00/01 and 0 for op 10/11.
REQ-024 Arithmetic SHALL wrap modulo 16; no saturation.
REQ-025 Requester input changes while not granted SHALL have no effect.

Reset
REQ-026 On rst: state IDLE, pointer 0 (req0 preferred), rsp_valid 0, rsp_data 0, rsp_err 0, rsp_id 0, busy 0, err_cnt 0, both ready 0 while rst high.
REQ-027 rst asserted in EXEC or RESP SHALL abandon the in-flight operation; no response is emitted for it.

Configuration
REQ-028 Macro ALU_ARBITER_ERR_CNT_EN defined: err_cnt SHALL increment by 1 on each RESP handshake with rsp_err=1, saturating at all-ones.
REQ-029 Macro undefined: err_cnt SHALL be constant 0 and no counter register exists.

Structure
REQ-030 Shared package alu_arb_pkg SHALL hold the opcode constants (OP_ADD, OP_SUB, OP_NAND, OP_XOR) and the FSM state typedef.
REQ-031 Block SHALL instantiate exactly one sub-module, the team's 4-bit ALU (ALU), as the shared datapath; no duplicate arithmetic logic.

Verification
REQ-032 Only req0 valid, op 00, a=0111, b=0001 -> req0_ready cycle N, rsp_valid N+2, rsp_data 1000, rsp_err 1, rsp_id 0.
REQ-033 Both valid after reset, req0 NAND 1100/1010, req1 XOR 1100/1010 -> first rsp_id 0 data 0111 err 0, second rsp_id 1 data 0110 err 0.
REQ-034 req1 op 01 a=0011 b=0101, rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data 1110, rsp_err 0 stable throughout, no new ready until handshake.
REQ-035 Both valid continuously for 4 grants -> grant order 0,1,0,1; each rsp_valid exactly 2 cycles after its ready.
REQ-036 rst pulsed during EXEC -> next cycle IDLE, rsp_valid 0, busy 0, no response for dropped op; pointer back to 0.
REQ-037 With ALU_ARBITER_ERR_CNT_EN, 17 overflowing adds (0111+0001) -> err_cnt saturates at 1111; without macro err_cnt stays 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared opcode constants and FSM state type for the ALU arbiter.
package alu_arb_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// 4-bit ALU: add/sub wrap modulo 16 with signed-overflow flag; NAND/XOR never flag.
module alu_arbiter_alu
  import alu_arb_pkg::*;
(
  input  logic [1:0] i_op,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [3:0] o_data,
  output logic       o_ovf
);

  always_comb begin
    o_data = '0;
    o_ovf  = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_data = i_a + i_b;
        o_ovf  = (i_a[3] == i_b[3]) && (o_data[3] != i_a[3]);
      end
      OP_SUB: begin
        o_data = i_a - i_b;
        o_ovf  = (i_a[3] != i_b[3]) && (o_data[3] != i_a[3]);
      end
      OP_NAND: o_data = ~(i_a & i_b);
      default: o_data = i_a ^ i_b;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared 4-bit ALU.
// ALU_ARBITER_ERR_CNT_EN adds a saturating overflow-event counter on err_cnt.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [1:0]           req0_op,
  input  logic [3:0]           req0_a,
  input  logic [3:0]           req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [1:0]           req1_op,
  input  logic [3:0]           req1_a,
  input  logic [3:0]           req1_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [3:0]           rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_e     r_state;
  logic       r_ptr;
  logic [1:0] r_op;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic       r_id;
  logic       r_rsp_valid;
  logic [3:0] r_rsp_data;
  logic       r_rsp_err;
  logic       r_rsp_id;

  logic       w_idle;
  logic       w_grant0;
  logic       w_grant1;
  logic [3:0] w_alu_data;
  logic       w_alu_ovf;

  // Pointer only breaks ties; a lone requester wins regardless of it.
  assign w_idle   = (r_state == StIdle) && !rst;
  assign w_grant0 = w_idle && req0_valid && (!req1_valid || !r_ptr);
  assign w_grant1 = w_idle && req1_valid && (!req0_valid || r_ptr);

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign rsp_id     = r_rsp_id;
  assign busy       = (r_state != StIdle);

  alu_arbiter_alu u_alu (
    .i_op   (r_op),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_data (w_alu_data),
    .o_ovf  (w_alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_ptr       <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_id    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_grant0 || w_grant1) begin
            r_op    <= w_grant1 ? req1_op : req0_op;
            r_a     <= w_grant1 ? req1_a : req0_a;
            r_b     <= w_grant1 ? req1_b : req0_b;
            r_id    <= w_grant1;
            r_ptr   <= w_grant0;
            r_state <= StExec;
          end
        end
        StExec: begin
          r_rsp_data  <= w_alu_data;
          r_rsp_err   <= w_alu_ovf;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef ALU_ARBITER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if ((r_state == StResp) && rsp_ready && r_rsp_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; follows ALU_ARBITER_ERR_CNT_EN if defined.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

`ifdef ALU_ARBITER_ERR_CNT_EN
  localparam logic [3:0] ErrOne = 4'h1;
  localparam logic [3:0] ErrSat = 4'hF;
`else
  localparam logic [3:0] ErrOne = 4'h0;
  localparam logic [3:0] ErrSat = 4'h0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [3:0] rsp_data;
  logic [3:0] err_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.ERR_CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Response bundle packed as {rsp_valid, rsp_id, rsp_data, rsp_err}.
  function automatic logic [15:0] rsp_vec();
    return {9'd0, rsp_valid, rsp_id, rsp_data, rsp_err};
  endfunction

  initial begin
    logic       exp_id [4];
    logic [3:0] exp_d  [4];
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_d  = '{4'h7, 4'h6, 4'h7, 4'h6};

    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 4'h7; req0_b = 4'h1;
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 4'h7; req1_b = 4'h1;
    tick();
    tick();
    chk("reset_ctrl", {10'd0, req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_err}, 16'h0);
    chk("reset_data", {12'd0, rsp_data}, 16'h0);
    chk("reset_errcnt", {12'd0, err_cnt}, 16'h0);

    // Lone req0, overflowing add.
    req1_valid = 1'b0; rst = 1'b0;
    #1;
    chk("add_grant", {14'd0, req0_ready, req1_ready}, 16'h2);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("add_exec", {14'd0, rsp_valid, busy}, 16'h1);
    tick();
    chk("add_resp", rsp_vec(), {9'd0, 1'b1, 1'b0, 4'h8, 1'b1});
    rsp_ready = 1'b1;
    tick();
    chk("add_done", {14'd0, rsp_valid, busy}, 16'h0);

    // Both valid continuously: NAND vs XOR, alternating grants.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_op = OP_NAND; req0_a = 4'hC; req0_b = 4'hA;
    req1_valid = 1'b1; req1_op = OP_XOR;  req1_a = 4'hC; req1_b = 4'hA;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("rr_grant", {14'd0, req0_ready, req1_ready}, exp_id[g] ? 16'h1 : 16'h2);
      tick();
      if (g == 0) begin
        req0_op = OP_ADD; req0_a = 4'h0;
        #1;
      end
      chk("rr_exec", {13'd0, rsp_valid, req0_ready, req1_ready}, 16'h0);
      tick();
      chk("rr_resp", rsp_vec(), {9'd0, 1'b1, exp_id[g], exp_d[g], 1'b0});
      req0_op = OP_NAND; req0_a = 4'hC;
      tick();
      #1;
    end

    // Backpressure: req1 sub held in RESP for 5 cycles.
    req0_valid = 1'b0; rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 4'h3; req1_b = 4'h5;
    #1;
    chk("sub_grant", {14'd0, req0_ready, req1_ready}, 16'h1);
    tick();
    req0_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("sub_hold", {rsp_vec()[13:0], req0_ready, req1_ready},
          {7'd0, 1'b1, 1'b1, 4'hE, 1'b0, 2'b00});
      tick();
    end
    req1_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    req0_op = OP_ADD; req0_a = 4'h7; req0_b = 4'h1;
    #1;
    chk("post_hold_grant", {13'd0, rsp_valid, req0_ready, req1_ready}, 16'h2);

    // Reset during EXEC drops the op and restores the pointer.
    tick();
    req0_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_exec", {14'd0, busy, rsp_valid}, 16'h0);
    tick();
    tick();
    chk("rst_no_rsp", {14'd0, busy, rsp_valid}, 16'h0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_ptr", {14'd0, req0_ready, req1_ready}, 16'h2);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("ovf_resp0", rsp_vec(), {9'd0, 1'b1, 1'b0, 4'h8, 1'b1});
    tick();
    chk("errcnt_one", {12'd0, err_cnt}, {12'd0, ErrOne});

    // 17 more overflowing adds drive the counter into saturation.
    for (int i = 0; i < 17; i++) begin
      req0_valid = 1'b1;
      #1;
      chk("ovf_grant", {14'd0, req0_ready, req1_ready}, 16'h2);
      tick();
      req0_valid = 1'b0;
      tick();
      chk("ovf_resp", rsp_vec(), {9'd0, 1'b1, 1'b0, 4'h8, 1'b1});
      tick();
    end
    chk("errcnt_sat", {12'd0, err_cnt}, {12'd0, ErrSat});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
